// File: rtl/imm_extend_pkg.sv
// Shared definitions for the ID-stage immediate extender: mode encodings,
// skid buffer state encoding and the width-generic extension function.
package imm_extend_pkg;

  localparam logic [1:0] MODE_SIGN   = 2'd0;
  localparam logic [1:0] MODE_ZERO   = 2'd1;
  localparam logic [1:0] MODE_UPPER  = 2'd2;
  localparam logic [1:0] MODE_BRANCH = 2'd3;

  // Widest datapath the extension function supports; callers size-cast down.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  // Extends the low in_w bits of imm to out_w bits; bits at and above out_w are zero.
  function automatic logic [MAX_W-1:0] extend(
    input logic [MAX_W-1:0] imm,
    input logic [1:0]       mode,
    input int               in_w,
    input int               out_w
  );
    logic [MAX_W-1:0] in_mask;
    logic [MAX_W-1:0] out_mask;
    logic [MAX_W-1:0] lo;
    logic [MAX_W-1:0] sext;
    logic [MAX_W-1:0] res;
    logic             sign;
    in_mask  = ~({MAX_W{1'b1}} << in_w);
    out_mask = ~({MAX_W{1'b1}} << out_w);
    lo       = imm & in_mask;
    sign     = |(imm & ({{(MAX_W-1){1'b0}}, 1'b1} << (in_w - 1)));
    sext     = sign ? (lo | ~in_mask) : lo;
    res      = {MAX_W{1'b0}};
    case (mode)
      MODE_SIGN:   res = sext;
      MODE_ZERO:   res = lo;
      MODE_UPPER:  res = lo << (out_w - in_w);
      MODE_BRANCH: res = sext << 2;
      default:     res = {MAX_W{1'b0}};
    endcase
    return res & out_mask;
  endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush; strict FIFO
// order, full throughput under backpressure, in_ready held low during reset.
module imm_skid_buf
  import imm_extend_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  buf_state_e   state_r;
  buf_state_e   state_s;
  logic [W-1:0] main_r;
  logic [W-1:0] main_s;
  logic [W-1:0] skid_r;
  logic [W-1:0] skid_s;
  logic         accept_s;
  logic         drain_s;

  assign in_ready  = !rst && (state_r != BUF_TWO);
  assign accept_s  = in_valid && in_ready;
  assign drain_s   = (state_r != BUF_EMPTY) && out_ready;
  assign out_valid = (state_r != BUF_EMPTY);
  assign out_data  = main_r;

  // Next-state and entry steering; flush drops held entries and any same-cycle accept.
  always_comb begin
    state_s = state_r;
    main_s  = main_r;
    skid_s  = skid_r;
    if (flush) begin
      state_s = BUF_EMPTY;
    end else begin
      case (state_r)
        BUF_EMPTY: begin
          if (accept_s) begin
            state_s = BUF_ONE;
            main_s  = in_data;
          end else begin
            state_s = BUF_EMPTY;
          end
        end
        BUF_ONE: begin
          if (accept_s && !drain_s) begin
            state_s = BUF_TWO;
            skid_s  = in_data;
          end else if (accept_s) begin
            main_s  = in_data;
          end else if (drain_s) begin
            state_s = BUF_EMPTY;
          end else begin
            state_s = BUF_ONE;
          end
        end
        BUF_TWO: begin
          if (drain_s) begin
            state_s = BUF_ONE;
            main_s  = skid_r;
          end else begin
            state_s = BUF_TWO;
          end
        end
        default: begin
          state_s = BUF_EMPTY;
        end
      endcase
    end
  end

  // State and data registers; data cleared on reset so out_data is never X.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= BUF_EMPTY;
      main_r  <= {W{1'b0}};
      skid_r  <= {W{1'b0}};
    end else begin
      state_r <= state_s;
      main_r  <= main_s;
      skid_r  <= skid_s;
    end
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined MIPS ID-stage immediate extender (SIGN/ZERO/UPPER/BRANCH) behind a
// 2-entry skid buffer. Define IMM_EXTEND_PERF_EN to add transfer/stall counters.
module imm_extend_pipe
  import imm_extend_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_neg
`ifdef IMM_EXTEND_PERF_EN
  ,
  output logic [31:0]      perf_xfers,
  output logic [31:0]      perf_stalls
`endif
);

  if (IN_W < 2 || OUT_W <= IN_W || OUT_W > MAX_W) begin : g_param_check
    $error("imm_extend_pipe: need 2 <= IN_W < OUT_W <= MAX_W");
  end

  logic [OUT_W-1:0] ext_s;

  assign ext_s   = OUT_W'(extend(MAX_W'(in_imm), in_mode, IN_W, OUT_W));
  assign out_neg = out_data[OUT_W-1];

  imm_skid_buf #(
    .W (OUT_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (ext_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

`ifdef IMM_EXTEND_PERF_EN
  logic [31:0] perf_xfers_r;
  logic [31:0] perf_stalls_r;

  assign perf_xfers  = perf_xfers_r;
  assign perf_stalls = perf_stalls_r;

  // Free-running wrap-around counters; flush deliberately leaves them intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_xfers_r  <= 32'd0;
      perf_stalls_r <= 32'd0;
    end else begin
      if (out_valid && out_ready) begin
        perf_xfers_r <= perf_xfers_r + 32'd1;
      end else begin
        perf_xfers_r <= perf_xfers_r;
      end
      if (out_valid && !out_ready) begin
        perf_stalls_r <= perf_stalls_r + 32'd1;
      end else begin
        perf_stalls_r <= perf_stalls_r;
      end
    end
  end
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed scoreboard bench for imm_extend_pipe at IN_W=4, OUT_W=16.
module tb_imm_extend_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_neg;
`ifdef IMM_EXTEND_PERF_EN
  logic [31:0] perf_xfers;
  logic [31:0] perf_stalls;
`endif

  int checks   = 0;
  int failures = 0;
  logic [15:0] sbq[$];

  imm_extend_pipe #(.IN_W(4), .OUT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_neg   (out_neg)
`ifdef IMM_EXTEND_PERF_EN
    ,
    .perf_xfers  (perf_xfers),
    .perf_stalls (perf_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one immediate, waits (bounded) for acceptance, records expected result.
  task automatic send(input logic [3:0] imm, input logic [1:0] mode, input logic [15:0] exp);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", {31'd0, in_ready}, 32'd1);
    if (in_ready && !flush) sbq.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_check(input string tag, input logic [3:0] imm, input logic [1:0] mode,
                            input logic [15:0] exp);
    send(imm, mode, exp);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"}, {16'd0, out_data}, {16'd0, exp});
    check({tag, "_neg"}, {31'd0, out_neg}, {31'd0, exp[15]});
    step();
  endtask

  // Scoreboard: every output transfer must match the oldest expected entry.
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst) begin
      sbq.delete();
    end else begin
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        assert (sbq.size() > 0) else begin
          failures++;
          $error("FAIL sb_unexpected observed=%h expected=none", out_data);
        end
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          check("sb_data", {16'd0, out_data}, {16'd0, e});
          check("sb_neg", {31'd0, out_neg}, {31'd0, e[15]});
        end
      end
      if (flush) sbq.delete();
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_imm = 4'd0; in_mode = 2'd0; out_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_out_neg", {31'd0, out_neg}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // Mode arithmetic, one-cycle latency from an empty buffer.
    send_check("sign_neg",   4'b1000, 2'd0, 16'hFFF8);
    send_check("sign_pos",   4'b0001, 2'd0, 16'h0001);
    send_check("zero",       4'b1111, 2'd1, 16'h000F);
    send_check("upper",      4'b1001, 2'd2, 16'h9000);
    send_check("branch_neg", 4'b1001, 2'd3, 16'hFFE4);
    send_check("branch_pos", 4'b0111, 2'd3, 16'h001C);

    // Backpressure: two accepted, third blocked, then drained with no bubble.
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 4'b0011; in_mode = 2'd0;
    @(negedge clk); check("bp_rdy0", {31'd0, in_ready}, 32'd1); sbq.push_back(16'h0003);
    step();
    in_imm = 4'b1010; in_mode = 2'd1;
    @(negedge clk); check("bp_rdy1", {31'd0, in_ready}, 32'd1); sbq.push_back(16'h000A);
    step();
    in_imm = 4'b0101; in_mode = 2'd2;
    @(negedge clk); check("bp_full", {31'd0, in_ready}, 32'd0);
    step();
    check("bp_hold0", {16'd0, out_data}, 32'h0003);
    step();
    check("bp_hold1", {16'd0, out_data}, 32'h0003);
    check("bp_full2", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    step();
    check("bp_second_v", {31'd0, out_valid}, 32'd1);
    check("bp_second", {16'd0, out_data}, 32'h000A);
    @(negedge clk); check("bp_rdy2", {31'd0, in_ready}, 32'd1); sbq.push_back(16'h5000);
    step();
    in_valid = 1'b0;
    check("bp_third_v", {31'd0, out_valid}, 32'd1);
    check("bp_third", {16'd0, out_data}, 32'h5000);
    step();
    check("bp_empty", {31'd0, out_valid}, 32'd0);

    // Flush with the buffer full and a pending offer.
    out_ready = 1'b0;
    send(4'b0010, 2'd0, 16'h0002);
    send(4'b0100, 2'd1, 16'h0004);
    in_valid = 1'b1; in_imm = 4'b0110; in_mode = 2'd0; flush = 1'b1;
    @(negedge clk); check("fl_two_ready", {31'd0, in_ready}, 32'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", {31'd0, out_valid}, 32'd0);
    check("fl_ready", {31'd0, in_ready}, 32'd1);
    // Flush in ONE: the same-cycle accept must be dropped.
    send(4'b0001, 2'd1, 16'h0001);
    in_valid = 1'b1; in_imm = 4'b1110; in_mode = 2'd1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl1_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    step(); step();
    check("fl_quiet", {31'd0, out_valid}, 32'd0);
    send_check("fl_after", 4'b0110, 2'd0, 16'h0006);

    // Reset in the middle of a stalled stream.
    out_ready = 1'b0;
    send(4'b0011, 2'd1, 16'h0003);
    check("mr_pre_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1; in_valid = 1'b1; in_imm = 4'b0101; in_mode = 2'd0;
    @(negedge clk); check("mr_ready_low", {31'd0, in_ready}, 32'd0);
    step();
    check("mr_valid", {31'd0, out_valid}, 32'd0);
    check("mr_data", {16'd0, out_data}, 32'd0);
    check("mr_neg", {31'd0, out_neg}, 32'd0);
    check("mr_ready", {31'd0, in_ready}, 32'd0);
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("mr_ready_back", {31'd0, in_ready}, 32'd1);
    check("mr_still_empty", {31'd0, out_valid}, 32'd0);
    send_check("mr_first", 4'b1000, 2'd3, 16'hFFE0);

`ifdef IMM_EXTEND_PERF_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    send(4'b0001, 2'd0, 16'h0001); step();
    send(4'b0010, 2'd0, 16'h0002); step();
    send(4'b0011, 2'd0, 16'h0003); step();
    send(4'b0100, 2'd0, 16'h0004); step();
    out_ready = 1'b0;
    send(4'b0101, 2'd0, 16'h0005);
    step(); step(); step();
    out_ready = 1'b1;
    step();
    check("perf_xfers", perf_xfers, 32'd5);
    check("perf_stalls", perf_stalls, 32'd3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("perf_xfers_fl", perf_xfers, 32'd5);
    check("perf_stalls_fl", perf_stalls, 32'd3);
    rst = 1'b1;
    step();
    check("perf_xfers_rst", perf_xfers, 32'd0);
    check("perf_stalls_rst", perf_stalls, 32'd0);
    rst = 1'b0;
    step();
`endif

    out_ready = 1'b1;
    step(); step(); step();
    check("sb_drained", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
